// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - data-memory responder: word RAM plus optional MMIO port
// Define RV32_DMEM_MMIO_EN to decode the MMIO window; otherwise it reads as unmapped.
`timescale 1ns/1ps
module rv32_dmem_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter logic [31:0] MMIO_SIZE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [67:0] req,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        mmio_valid,
  output logic        mmio_write,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_wstrb,
  input  logic        mmio_ready,
  input  logic [31:0] mmio_rdata
);

  localparam int          AW       = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_SPAN = 32'(RAM_WORDS) << 2;
`ifdef RV32_DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  op;
  } memory_request_t;

  typedef enum logic [1:0] {IDLE, MMIO_WAIT, MMIO_RSP} state_t;

  memory_request_t r;
  state_t          state_q, state_d;
  logic            rsp_q, rsp_d, err_q, err_d, load_q, load_d, uns_q, uns_d;
  logic [1:0]      off_q, off_d, size_q, size_d;
  logic            mmio_write_q, mmio_write_d;
  logic [31:0]     mmio_addr_q, mmio_addr_d, mmio_wdata_q, mmio_wdata_d;
  logic [3:0]      mmio_wstrb_q, mmio_wstrb_d;
  logic [31:0]     mmio_rsp_q, mmio_rsp_d;
  logic [31:0]     ram_q [RAM_WORDS];
  logic [31:0]     rd_q;

  logic            accept, is_store, uns, op_ok, misaligned, ram_hit, mmio_hit;
  logic            ram_we, ram_re;
  logic [1:0]      size;
  logic [31:0]     ram_off, mmio_off, wdata;
  logic [3:0]      wstrb;
  logic [AW-1:0]   ram_idx;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] sz, input logic unsgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      2'b00:   extract = unsgn ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = unsgn ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  assign r         = req;
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign is_store  = r.op[3];
  assign uns       = r.op[2];
  assign size      = r.op[1:0];
  // Legal codes: LB/LH/LW, LBU/LHU, SB/SH/SW; everything else is a silent no-op.
  assign op_ok     = (size != 2'b11) && (is_store ? !uns : !(uns && size == 2'b10));
  assign misaligned = (size == 2'b01 && r.addr[0]) || (size == 2'b10 && r.addr[1:0] != 2'b00);
  // Offset compares avoid an always-true lower bound when a base is zero.
  assign ram_off   = r.addr - RAM_BASE;
  assign mmio_off  = r.addr - MMIO_BASE;
  assign ram_hit   = ram_off < RAM_SPAN;
  assign mmio_hit  = MMIO_EN && (mmio_off < MMIO_SIZE);
  assign ram_idx   = ram_off[AW+1:2];

  always_comb begin
    wdata = r.data;
    wstrb = 4'b1111;
    case (size)
      2'b00: begin wdata = {4{r.data[7:0]}};  wstrb = 4'b0001 << r.addr[1:0]; end
      2'b01: begin wdata = {2{r.data[15:0]}}; wstrb = 4'b0011 << r.addr[1:0]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rsp_d        = 1'b0;
    err_d        = 1'b0;
    load_d       = 1'b0;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    mmio_write_d = mmio_write_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    mmio_wstrb_d = mmio_wstrb_q;
    mmio_rsp_d   = mmio_rsp_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && op_ok) begin
          off_d  = r.addr[1:0];
          size_d = size;
          uns_d  = uns;
          if (misaligned || !(ram_hit || mmio_hit)) begin
            rsp_d = 1'b1;
            err_d = 1'b1;
          end else if (ram_hit) begin
            rsp_d  = 1'b1;
            load_d = !is_store;
            ram_we = is_store;
            ram_re = !is_store;
          end else begin
            state_d      = MMIO_WAIT;
            mmio_write_d = is_store;
            mmio_addr_d  = {r.addr[31:2], 2'b00};
            mmio_wdata_d = is_store ? wdata : 32'h0;
            mmio_wstrb_d = is_store ? wstrb : 4'h0;
          end
        end
      end
      MMIO_WAIT: begin
        if (mmio_ready) begin
          mmio_rsp_d = mmio_write_q ? 32'h0 : extract(mmio_rdata, off_q, size_q, uns_q);
          state_d    = MMIO_RSP;
        end
      end
      MMIO_RSP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rsp_q        <= 1'b0;
      err_q        <= 1'b0;
      load_q       <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      mmio_write_q <= 1'b0;
      mmio_addr_q  <= 32'h0;
      mmio_wdata_q <= 32'h0;
      mmio_wstrb_q <= 4'h0;
      mmio_rsp_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      rsp_q        <= rsp_d;
      err_q        <= err_d;
      load_q       <= load_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      mmio_write_q <= mmio_write_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_wstrb_q <= mmio_wstrb_d;
      mmio_rsp_q   <= mmio_rsp_d;
    end
  end

  // RAM array and its read register are deliberately unreset.
  always_ff @(posedge clk) begin
    if (ram_re) rd_q <= ram_q[ram_idx];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) ram_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rsp_data = 32'h0;
    if (rsp_q && load_q)          rsp_data = extract(rd_q, off_q, size_q, uns_q);
    else if (state_q == MMIO_RSP) rsp_data = mmio_rsp_q;
  end

  assign rsp_valid  = rsp_q || (state_q == MMIO_RSP);
  assign rsp_error  = rsp_q && err_q;
  assign mmio_valid = MMIO_EN && (state_q == MMIO_WAIT);
  assign mmio_write = MMIO_EN && mmio_write_q;
  assign mmio_addr  = MMIO_EN ? mmio_addr_q  : 32'h0;
  assign mmio_wdata = MMIO_EN ? mmio_wdata_q : 32'h0;
  assign mmio_wstrb = MMIO_EN ? mmio_wstrb_q : 4'h0;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - directed scoreboard bench for rv32_dmem_responder
`timescale 1ns/1ps
module tb_rv32_dmem_responder;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010, NOP = 4'b1111;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [67:0] req;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        mmio_valid;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb [$];

    rv32_dmem_responder dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req        (req),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .mmio_valid (mmio_valid),
        .mmio_write (mmio_write),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_wstrb (mmio_wstrb),
        .mmio_ready (mmio_ready),
        .mmio_rdata (mmio_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [32:0] e;
        @(posedge clk);
        #1;
        if (rsp_valid) begin
            if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'h0);
            else begin
                e = sb.pop_front();
                check("rsp_error", 32'(rsp_error), 32'(e[32]));
                check("rsp_data", rsp_data, e[31:0]);
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input bit push, input bit err, input logic [31:0] exp);
        req_valid = 1'b1;
        req       = {addr, data, op};
        check("req_ready", 32'(req_ready), 32'h1);
        if (push) sb.push_back({err, exp});
        tick();
    endtask

    task automatic done();
        check("latency", 32'(sb.size()), 32'h0);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req       = '0;
        tick();
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req = '0; mmio_ready = 1'b0; mmio_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_mmio_valid", 32'(mmio_valid), 32'h0);
        check("rst_mmio_write", 32'(mmio_write), 32'h0);
        check("rst_mmio_addr", mmio_addr, 32'h0);
        check("rst_mmio_wdata", mmio_wdata, 32'h0);
        check("rst_mmio_wstrb", 32'(mmio_wstrb), 32'h0);
        rstn = 1'b1;

        send(SW,  32'h10, 32'h8077_66F5, 1, 0, 32'h0);         done();
        send(LB,  32'h10, 32'h0, 1, 0, 32'hFFFF_FFF5);          done();
        send(LBU, 32'h10, 32'h0, 1, 0, 32'h0000_00F5);          done();
        send(LH,  32'h12, 32'h0, 1, 0, 32'hFFFF_8077);          done();
        send(SB,  32'h13, 32'h0000_00AA, 1, 0, 32'h0);          done();
        send(LW,  32'h10, 32'h0, 1, 0, 32'hAA77_66F5);          done();
        send(LHU, 32'h12, 32'h0, 1, 0, 32'h0000_AA77);          done();
        send(LH,  32'h12, 32'h0, 1, 0, 32'hFFFF_AA77);          done();
        send(SW,  32'h20, 32'h1234_5678, 1, 0, 32'h0);          done();
        send(LW,  32'h20, 32'h0, 1, 0, 32'h1234_5678);          done();

        send(LW,  32'h22, 32'h0, 1, 1, 32'h0);                  done();
        send(SH,  32'h21, 32'hFFFF_FFFF, 1, 1, 32'h0);          done();
        send(LW,  32'h4000_0000, 32'h0, 1, 1, 32'h0);           done();
        send(LW,  32'h4000, 32'h0, 1, 1, 32'h0);                done();
        send(LW,  32'h20, 32'h0, 1, 0, 32'h1234_5678);          done();

        send(SW,  32'h3FFC, 32'hCAFE_F00D, 1, 0, 32'h0);        done();
        send(SH,  32'h3FFE, 32'h0000_1357, 1, 0, 32'h0);        done();
        send(LW,  32'h3FFC, 32'h0, 1, 0, 32'h1357_F00D);        done();

        send(NOP, 32'h10, 32'hFFFF_FFFF, 0, 0, 32'h0);
        check("nop_no_rsp", 32'(rsp_valid), 32'h0);
        send(4'b1011, 32'h10, 32'h0, 0, 0, 32'h0);
        check("undef_store_no_rsp", 32'(rsp_valid), 32'h0);
        send(4'b0110, 32'h10, 32'h0, 0, 0, 32'h0);
        check("undef_load_no_rsp", 32'(rsp_valid), 32'h0);
        send(LW,  32'h10, 32'h0, 1, 0, 32'hAA77_66F5);          done();
        idle();
        check("idle_no_rsp", 32'(rsp_valid), 32'h0);

`ifdef RV32_DMEM_MMIO_EN
        send(LHU, 32'h8000_0006, 32'h0, 1, 0, 32'h0000_BEEF);
        req_valid = 1'b0;
        check("mmio_valid", 32'(mmio_valid), 32'h1);
        check("mmio_addr", mmio_addr, 32'h8000_0004);
        check("mmio_wstrb", 32'(mmio_wstrb), 32'h0);
        check("mmio_write", 32'(mmio_write), 32'h0);
        check("wait_req_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_mmio_valid", 32'(mmio_valid), 32'h1);
            check("wait_req_ready", 32'(req_ready), 32'h0);
            check("wait_mmio_addr", mmio_addr, 32'h8000_0004);
        end
        mmio_ready = 1'b1; mmio_rdata = 32'hBEEF_0000;
        tick();
        mmio_ready = 1'b0; mmio_rdata = 32'h0;
        done();
        check("rsp_req_ready", 32'(req_ready), 32'h0);
        tick();
        check("back_idle_ready", 32'(req_ready), 32'h1);
        check("back_idle_mmio_valid", 32'(mmio_valid), 32'h0);

        send(SB, 32'h8000_0011, 32'h0000_005A, 1, 0, 32'h0);
        req_valid = 1'b0;
        check("mmio_st_write", 32'(mmio_write), 32'h1);
        check("mmio_st_addr", mmio_addr, 32'h8000_0010);
        check("mmio_st_wdata", mmio_wdata, 32'h5A5A_5A5A);
        check("mmio_st_wstrb", 32'(mmio_wstrb), 32'h2);
        mmio_ready = 1'b1;
        tick();
        mmio_ready = 1'b0;
        done();
        tick();

        send(LW, 32'h8000_0002, 32'h0, 1, 1, 32'h0);            done();
        send(LW, 32'h8000_0100, 32'h0, 1, 1, 32'h0);            done();

        send(LW, 32'h8000_0000, 32'h0, 0, 0, 32'h0);
        req_valid = 1'b0;
        check("pre_rst_mmio_valid", 32'(mmio_valid), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_mmio_valid", 32'(mmio_valid), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h1);
`else
        send(LW, 32'h8000_0000, 32'h0, 1, 1, 32'h0);            done();
        check("no_mmio_valid", 32'(mmio_valid), 32'h0);
        send(SW, 32'h8000_0010, 32'h1, 1, 1, 32'h0);            done();
        check("no_mmio_wstrb", 32'(mmio_wstrb), 32'h0);
        req_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h1);
`endif

        @(posedge clk);
        #1 rstn = 1'b1;
        idle();
        check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        send(LW, 32'h10, 32'h0, 1, 0, 32'hAA77_66F5);           done();
        idle();
        check("drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_dmem_responder.md
Name: rv32_dmem_responder

Overview:
- Responder side of the core's data-memory request bus (`memory_request_t`: addr, data, `mem_op_t` op).
- Sits between the core's memory stage and a word-organised data RAM plus one MMIO peripheral port.
- Decodes the address, performs byte/half/word stores with lane steering, and returns sign- or zero-extended load data.
- Flags misaligned and unmapped accesses as errors.

Parameters:
- RAM_BASE, 32'h0000_0000, byte base address of the internal RAM.
- RAM_WORDS, 4096, RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'h8000_0000, byte base address of the MMIO window.
- MMIO_SIZE, 32'h0000_0100, MMIO window size in bytes (power of two).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when `req_valid && req_ready`
- req  in  68  `memory_request_t` {addr[31:0], data[31:0], op[3:0]}
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  load result; 0 for stores and errors
- rsp_error  out  1  misaligned or unmapped access, qualified by `rsp_valid`
- mmio_valid  out  1  MMIO request; held until `mmio_ready`
- mmio_write  out  1  1 = store
- mmio_addr  out  32  byte address, word aligned (addr[1:0] forced to 0)
- mmio_wdata  out  32  lane-steered store data
- mmio_wstrb  out  4  byte enables; 0 for loads
- mmio_ready  in  1  MMIO completes this cycle
- mmio_rdata  in  32  full-word read data, valid with `mmio_ready`

Behaviour:
- Reset is asynchronous and active-low on `rstn`, single clock `clk`. State returns to IDLE.
  - Outputs in reset: `rsp_valid`, `rsp_error`, `mmio_valid` = 0; `rsp_data`, `mmio_*` = 0; `req_ready` = 1.
  - RAM contents are not reset.
- Op decode:
  - op[3] = 1 is a store; op[1:0] is size (00 byte, 01 half, 10 word); op[2] = 1 is an unsigned load.
  - `MEM_NOP` (4'b1111) and undefined codes: accepted silently, no response, no side effect.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0. A misaligned access gives an error response and has no side effect.
- Address map:
  - RAM hit: `RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS`.
  - MMIO hit: `MMIO_BASE <= addr < MMIO_BASE + MMIO_SIZE`.
  - Anything else is an error response.
- Store lanes:
  - SB: data[7:0] replicated to all lanes, wstrb = 1 << addr[1:0].
  - SH: data[15:0] replicated, wstrb = 4'b0011 << addr[1:0].
  - SW: wstrb = 4'b1111.
- Load extract: select byte or half by addr[1:0] from the read word, then sign- or zero-extend to 32 bits.
- FSM states: IDLE, MMIO_WAIT, MMIO_RSP.
  - IDLE:
    - `req_ready` = 1.
    - RAM and error requests are fully pipelined: accepted in cycle N, `rsp_valid` high in cycle N+1. Back-to-back requests are allowed every cycle.
    - An accepted MMIO request goes to MMIO_WAIT.
  - MMIO_WAIT:
    - `req_ready` = 0; `mmio_valid` = 1 with stable `mmio_*` fields.
    - On `mmio_ready`, latch the extracted load data and go to MMIO_RSP.
  - MMIO_RSP:
    - `rsp_valid` = 1 for one cycle, `req_ready` = 0, then return to IDLE.
    - MMIO latency is therefore 2 + (wait cycles).
  - A RAM response pending from cycle N-1 still issues in the same cycle the FSM enters MMIO_WAIT.
- RAM: synchronous read, byte-enabled write at the accept edge. A load one cycle after a store to the same word returns the new data. A load and store cannot coincide (single request port).
- Reset mid-operation: in MMIO_WAIT, `mmio_valid` drops immediately and the transaction is abandoned with no response.
- Address wrap is not supported: the ranges are compared on the full 32-bit addr, so no aliasing occurs.

Optional Feature:
- Macro `RV32_DMEM_MMIO_EN`.
- Defined: MMIO window decoded as above.
- Undefined:
  - MMIO window addresses decode as unmapped (error response).
  - FSM never leaves IDLE.
  - `mmio_valid`, `mmio_write`, `mmio_addr`, `mmio_wdata`, `mmio_wstrb` tied to 0; `mmio_ready` and `mmio_rdata` ignored.

Test Plan:
- Byte store/loads:
  - SW addr 0x10, data 0x8077_66F5.
  - LB 0x10 → 0xFFFF_FFF5; LBU 0x10 → 0x0000_00F5; LH 0x12 → 0xFFFF_8077.
  - Each response arrives 1 cycle after accept, `rsp_error` = 0.
- Byte lane merge: SB addr 0x13, data 0x0000_00AA after the SW above, then LW 0x10 → 0xAA77_66F5.
- Back-to-back read-after-write: SW 0x20 = 0x1234_5678 at cycle N, LW 0x20 at N+1 → `rsp_data` 0x1234_5678 at N+2; `req_ready` stays 1 throughout.
- Errors, each giving `rsp_valid` = 1, `rsp_error` = 1, `rsp_data` = 0, with RAM unchanged:
  - LW 0x22 (misaligned);
  - SH 0x21 (misaligned);
  - LW 0x4000_0000 (unmapped).
- MMIO (macro defined):
  - LHU 0x8000_0006 with `mmio_ready` delayed 3 cycles and `mmio_rdata` 0xBEEF_0000.
  - Expect `mmio_addr` 0x8000_0004, `mmio_wstrb` 0, `req_ready` 0 while waiting, then `rsp_data` 0x0000_BEEF one cycle after `mmio_ready`.
- Reset in MMIO_WAIT: deassert `rstn` mid-wait → `mmio_valid` 0 immediately, no `rsp_valid`; after release `req_ready` = 1 and a new LW 0x10 completes normally.
